// File: rtl/spi_sram_ctrl.sv
// SPI master for a 23K640 serial SRAM: one byte read or write per request.
// Frame is cmd, addr[15:8], addr[7:0], data sent MSB first in SPI mode 0.
// All SPI outputs are registered so the pins are glitch-free.
module spi_sram_ctrl #(
  parameter int unsigned p_clk_div = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_accept,
  input  logic        i_rd_n_wr,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_wdata,
  output logic        o_ready,
  output logic [7:0]  o_rdata,
  output logic        o_cs_n,
  output logic        o_sck,
  output logic        o_si,
  input  logic        i_so
);

  localparam logic [7:0] TimerLoad = 8'(p_clk_div - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_t;

  state_t      state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] frame_q, frame_d;
  logic [7:0]  rx_q, rx_d;
  logic        rd_q, rd_d;
  logic        cs_n_q, cs_n_d;
  logic        sck_q, sck_d;
  logic        si_q, si_d;
  logic        ready_q, ready_d;
  logic [7:0]  rdata_q, rdata_d;

  // State and datapath registers, cleared asynchronously by i_rst.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      frame_q   <= '0;
      rx_q      <= '0;
      rd_q      <= 1'b0;
      cs_n_q    <= 1'b1;
      sck_q     <= 1'b0;
      si_q      <= 1'b0;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      frame_q   <= frame_d;
      rx_q      <= rx_d;
      rd_q      <= rd_d;
      cs_n_q    <= cs_n_d;
      sck_q     <= sck_d;
      si_q      <= si_d;
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
    end
  end

  // Next-state logic: every phase lasts p_clk_div cycles, timed by a down-counter.
  always_comb begin
    logic [7:0] cmd;
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    rx_d      = rx_q;
    rd_d      = rd_q;
    cs_n_d    = cs_n_q;
    sck_d     = sck_q;
    si_d      = si_q;
    ready_d   = 1'b0;
    rdata_d   = rdata_q;
    cmd       = i_rd_n_wr ? 8'h03 : 8'h02;

    if (timer_q != 8'd0) begin
      timer_d = timer_q - 8'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (i_valid) begin
          state_d   = StSetup;
          timer_d   = TimerLoad;
          bit_cnt_d = '0;
          rd_d      = i_rd_n_wr;
          frame_d   = {cmd, i_addr, i_rd_n_wr ? 8'h00 : i_wdata};
          cs_n_d    = 1'b0;
          sck_d     = 1'b0;
          si_d      = cmd[7];
        end
      end
      StSetup: begin
        if (timer_q == 8'd0) begin
          // First rising edge; i_so is sampled on every rising edge so that the
          // last eight samples left in rx are the data byte.
          state_d = StShift;
          timer_d = TimerLoad;
          sck_d   = 1'b1;
          rx_d    = {rx_q[6:0], i_so};
        end
      end
      StShift: begin
        if (timer_q == 8'd0) begin
          timer_d = TimerLoad;
          if (sck_q) begin
            // Falling edge: the only point where o_si is allowed to move.
            sck_d     = 1'b0;
            frame_d   = {frame_q[30:0], 1'b0};
            si_d      = frame_q[30];
            bit_cnt_d = bit_cnt_q + 6'd1;
            if (bit_cnt_q == 6'd31) begin
              state_d = StHold;
            end
          end else begin
            sck_d = 1'b1;
            rx_d  = {rx_q[6:0], i_so};
          end
        end
      end
      StHold: begin
        if (timer_q == 8'd0) begin
          state_d = StGap;
          timer_d = TimerLoad;
          cs_n_d  = 1'b1;
          si_d    = 1'b0;
          ready_d = 1'b1;
          if (rd_q) begin
            rdata_d = rx_q;
          end
        end
      end
      StGap: begin
        if (timer_q == 8'd0) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign o_accept = (state_q == StIdle);
  assign o_ready  = ready_q;
  assign o_rdata  = rdata_q;
  assign o_cs_n   = cs_n_q;
  assign o_sck    = sck_q;
  assign o_si     = si_q;

endmodule

// File: tb/tb_spi_sram_ctrl.sv
// Self-checking bench for spi_sram_ctrl: a 23K640 slave model and scoreboards
// check frames and completions of the p=4 instance; a second p=1 instance
// checks the tight-timing corner.
module tb_spi_sram_ctrl;

  localparam int P = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        rd_n_wr = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic        so = 1'b0;
  logic        accept, ready, cs_n, sck, si;
  logic [7:0]  rdata;

  logic        valid1 = 1'b0;
  logic        rd_n_wr1 = 1'b0;
  logic [15:0] addr1 = '0;
  logic [7:0]  wdata1 = '0;
  logic        so1 = 1'b0;
  logic        accept1, ready1, cs_n1, sck1, si1;
  logic [7:0]  rdata1;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ready_cnt = 0;
  int frame_cnt = 0;

  typedef struct {logic [31:0] frame; int t;} frm_t;
  typedef struct {int t; logic [7:0] rdata;} rsp_t;
  frm_t fq[$];
  rsp_t rq[$];
  logic [7:0] exp_rdata = '0;
  logic [7:0] slave_byte = '0;

  spi_sram_ctrl #(.p_clk_div(P)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_accept(accept), .i_rd_n_wr(rd_n_wr),
    .i_addr(addr), .i_wdata(wdata), .o_ready(ready), .o_rdata(rdata), .o_cs_n(cs_n),
    .o_sck(sck), .o_si(si), .i_so(so)
  );

  spi_sram_ctrl #(.p_clk_div(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid1), .o_accept(accept1), .i_rd_n_wr(rd_n_wr1),
    .i_addr(addr1), .i_wdata(wdata1), .o_ready(ready1), .o_rdata(rdata1), .o_cs_n(cs_n1),
    .o_sck(sck1), .o_si(si1), .i_so(so1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model and bus monitor, sampled mid-cycle.
  logic        prev_cs = 1'b1;
  logic        prev_sck = 1'b0;
  logic        prev_si = 1'b0;
  int          nrise = 0;
  logic [31:0] rx_frame = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_cs = 1'b1; prev_sck = 1'b0; prev_si = 1'b0; nrise = 0; so = 1'b0;
    end else begin
      tests++;
      if (cs_n && sck) begin
        fails++; $display("FAIL sck_idle: cyc %0d sck=%b while cs_n=1, required 0", cyc, sck);
      end
      tests++;
      if (si !== prev_si && sck) begin
        fails++; $display("FAIL si_stable: cyc %0d si moved to %b while sck high", cyc, si);
      end
      if (prev_cs && !cs_n) begin
        nrise = 0; rx_frame = '0;
        tests++;
        if (fq.size() == 0) begin
          fails++; $display("FAIL cs_start: unexpected frame at cyc %0d, required none", cyc);
        end else if (cyc != fq[0].t + 1) begin
          fails++; $display("FAIL cs_start: cs_n fell at cyc %0d, required %0d", cyc, fq[0].t + 1);
        end
      end
      if (!cs_n && sck && !prev_sck) begin
        rx_frame = {rx_frame[30:0], si};
        nrise++;
      end
      if (!cs_n && !sck && prev_sck && nrise >= 24 && nrise <= 31) so = slave_byte[31 - nrise];
      if (!prev_cs && cs_n && fq.size() != 0) begin
        frm_t f;
        f = fq.pop_front();
        frame_cnt++;
        tests += 3;
        if (rx_frame !== f.frame) begin
          fails++; $display("FAIL si_frame: got %h, required %h", rx_frame, f.frame);
        end
        if (nrise != 32) begin
          fails++; $display("FAIL sck_rises: got %0d, required 32", nrise);
        end
        if (cyc != f.t + 1 + 65 * P) begin
          fails++; $display("FAIL cs_end: cs_n rose at cyc %0d, required %0d", cyc, f.t + 1 + 65 * P);
        end
      end
      if (ready) begin
        ready_cnt++;
        tests += 2;
        if (accept) begin
          fails++; $display("FAIL ready_accept: both high at cyc %0d", cyc);
        end
        if (rq.size() == 0) begin
          fails++; $display("FAIL ready_extra: unexpected o_ready at cyc %0d", cyc);
        end else begin
          rsp_t r;
          r = rq.pop_front();
          tests += 2;
          if (cyc != r.t) begin
            fails++; $display("FAIL ready_time: o_ready at cyc %0d, required %0d", cyc, r.t);
          end
          if (rdata !== r.rdata) begin
            fails++; $display("FAIL rdata: got %h, required %h", rdata, r.rdata);
          end
        end
      end
      prev_cs = cs_n; prev_sck = sck; prev_si = si;
    end
  end

  // Issue one request; returns handshake cycle. keep leaves i_valid high.
  task automatic do_req(input bit rd, input logic [15:0] a, input logic [7:0] wd,
                        input logic [7:0] rb, input bit keep, output int t);
    frm_t f;
    rsp_t r;
    valid = 1'b1; rd_n_wr = rd; addr = a; wdata = wd;
    for (int i = 0; i < 2000 && !accept; i++) @(negedge clk);
    tests++;
    if (!accept) begin
      fails++; $display("FAIL handshake: o_accept=%b after timeout, required 1", accept);
    end
    t = cyc;
    slave_byte = rb;
    f.frame = {rd ? 8'h03 : 8'h02, a, rd ? 8'h00 : wd};
    f.t = t;
    fq.push_back(f);
    if (rd) exp_rdata = rb;
    r.t = t + 1 + 65 * P;
    r.rdata = exp_rdata;
    rq.push_back(r);
    @(posedge clk);
    #1;
    if (!keep) valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000 && (fq.size() != 0 || rq.size() != 0); i++) @(negedge clk);
    tests++;
    if (fq.size() != 0 || rq.size() != 0) begin
      fails++;
      $display("FAIL timeout: %0d frames %0d responses pending, required 0", fq.size(), rq.size());
      fq.delete(); rq.delete();
    end
    repeat (P + 2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests += 6;
    if (accept !== 1'b1) begin fails++; $display("FAIL rst_accept: got %b, required 1", accept); end
    if (cs_n !== 1'b1)   begin fails++; $display("FAIL rst_cs_n: got %b, required 1", cs_n); end
    if (sck !== 1'b0)    begin fails++; $display("FAIL rst_sck: got %b, required 0", sck); end
    if (si !== 1'b0)     begin fails++; $display("FAIL rst_si: got %b, required 0", si); end
    if (ready !== 1'b0)  begin fails++; $display("FAIL rst_ready: got %b, required 0", ready); end
    if (rdata !== 8'h00) begin fails++; $display("FAIL rst_rdata: got %h, required 00", rdata); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    int t;
    do_req(1'b0, 16'h1234, 8'hA5, 8'h00, 1'b0, t);
    wait_done();
  endtask

  task automatic test_read();
    int t;
    do_req(1'b1, 16'h0010, 8'hFF, 8'h3C, 1'b0, t);
    wait_done();
    do_req(1'b1, 16'hE001, 8'h00, 8'hC3, 1'b0, t);
    wait_done();
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    do_req(1'b0, 16'hFFFF, 8'h5A, 8'h00, 1'b1, t1);
    do_req(1'b1, 16'h8001, 8'h00, 8'h96, 1'b0, t2);
    tests++;
    if (t2 - t1 != 66 * P + 1) begin
      fails++; $display("FAIL b2b_gap: second handshake at T+%0d, required T+%0d", t2 - t1, 66 * P + 1);
    end
    wait_done();
  endtask

  task automatic test_ignore();
    int t, r0, f0;
    r0 = ready_cnt; f0 = frame_cnt;
    do_req(1'b0, 16'h0F0F, 8'h11, 8'h00, 1'b0, t);
    while (cyc < t + 50) @(negedge clk);
    valid = 1'b1; rd_n_wr = 1'b1; addr = 16'hAAAA;
    @(negedge clk);
    valid = 1'b0;
    wait_done();
    repeat (10) @(negedge clk);
    tests += 2;
    if (ready_cnt - r0 != 1) begin
      fails++; $display("FAIL ignore_ready: got %0d pulses, required 1", ready_cnt - r0);
    end
    if (frame_cnt - f0 != 1 || cs_n !== 1'b1) begin
      fails++; $display("FAIL ignore_frame: got %0d frames cs_n=%b, required 1 frame cs_n=1",
                        frame_cnt - f0, cs_n);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    do_req(1'b0, 16'h0200, 8'h77, 8'h00, 1'b0, t);
    while (cyc < t + 100) @(negedge clk);
    rst = 1'b1;
    #1;
    tests += 3;
    if (cs_n !== 1'b1) begin fails++; $display("FAIL abort_cs_n: got %b, required 1", cs_n); end
    if (sck !== 1'b0)  begin fails++; $display("FAIL abort_sck: got %b, required 0", sck); end
    if (ready !== 1'b0) begin fails++; $display("FAIL abort_ready: got %b, required 0", ready); end
    fq.delete(); rq.delete();
    exp_rdata = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    tests += 2;
    if (accept !== 1'b1) begin fails++; $display("FAIL post_rst_accept: got %b, required 1", accept); end
    if (rdata !== 8'h00) begin fails++; $display("FAIL post_rst_rdata: got %h, required 00", rdata); end
    do_req(1'b1, 16'h0ABC, 8'h00, 8'h5A, 1'b0, t);
    wait_done();
  endtask

  task automatic test_p1();
    int t, rise_t, ready_t, acc_t, rises;
    logic        psck;
    logic [31:0] fr;
    rise_t = -1; ready_t = -1; acc_t = -1; rises = 0; psck = 1'b0; fr = '0;
    valid1 = 1'b1; rd_n_wr1 = 1'b0; addr1 = 16'hBEEF; wdata1 = 8'h42;
    t = cyc;
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sck1 && !psck) begin
        if (rise_t < 0) rise_t = cyc;
        rises++;
        fr = {fr[30:0], si1};
      end
      psck = sck1;
      if (ready1 && ready_t < 0) ready_t = cyc;
      if (accept1 && ready_t >= 0 && acc_t < 0) acc_t = cyc;
    end
    tests += 5;
    if (rise_t != t + 2)   begin fails++; $display("FAIL p1_rise: T+%0d, required T+2", rise_t - t); end
    if (ready_t != t + 66) begin fails++; $display("FAIL p1_ready: T+%0d, required T+66", ready_t - t); end
    if (acc_t != t + 67)   begin fails++; $display("FAIL p1_accept: T+%0d, required T+67", acc_t - t); end
    if (rises != 32)       begin fails++; $display("FAIL p1_rises: got %0d, required 32", rises); end
    if (fr !== 32'h02BEEF42) begin fails++; $display("FAIL p1_frame: got %h, required 02beef42", fr); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_ignore();
    test_reset_mid();
    test_p1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
